// File: rtl/iic_pkg.sv
// Shared I2C definitions: responder state encoding and operation codes used by
// both the master and slave sides.
package iic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_ACK_DEV,
    ST_ADDR_H,
    ST_ACK_AH,
    ST_ADDR_L,
    ST_ACK_AL,
    ST_WDATA,
    ST_ACK_WD,
    ST_RDATA,
    ST_MACK,
    ST_IGNORE
  } iic_state_e;

  localparam logic [1:0] P_W = 2'd1;
  localparam logic [1:0] P_R = 2'd2;

  localparam logic [3:0] BIT_LAST_RX  = 4'd7;  // count before the 8th data bit
  localparam logic [3:0] BIT_BYTE_END = 4'd8;  // all 8 data bits clocked
  localparam logic [3:0] BIT_ACK_HIGH = 4'd9;  // 9th (ACK) clock has risen

endpackage

// File: rtl/iic_line_sync.sv
// Brings the asynchronous SCL/SDA pad levels into the clock domain and
// produces registered single-cycle SCL edge and START/STOP event pulses.
module iic_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_sda_s,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_rise_q;
  logic       scl_fall_q;
  logic       start_q;
  logic       stop_q;
  logic       sda_q;

  // Reset to the idle bus level so no spurious edge is reported after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i_scl};
      sda_sync_q <= {sda_sync_q[0], i_sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
      scl_rise_q <= scl_sync_q[1] & ~scl_prev_q;
      scl_fall_q <= ~scl_sync_q[1] & scl_prev_q;
      start_q    <= scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
      stop_q     <= scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];
      sda_q      <= sda_sync_q[1];
    end
  end

  assign o_scl_rise = scl_rise_q;
  assign o_scl_fall = scl_fall_q;
  assign o_sda_s    = sda_q;
  assign o_start    = start_q;
  assign o_stop     = stop_q;

endmodule

// File: rtl/iic_slave_drive.sv
// EEPROM-style I2C responder: device address, 1-2 address bytes, then write
// data strobes or sequential reads from a fixed 1-cycle-latency local memory.
module iic_slave_drive
  import iic_pkg::*;
#(
  parameter logic [6:0] P_DEVICE_ADDR = 7'h50,
  parameter int         P_ADDR_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_iic_scl,
  input  logic                    i_iic_sda,
  output logic                    o_iic_sda_oe,
  output logic [P_ADDR_WIDTH-1:0] o_write_addr,
  output logic [7:0]              o_write_data,
  output logic                    o_write_valid,
  output logic [P_ADDR_WIDTH-1:0] o_read_addr,
  output logic                    o_read_req,
  input  logic [7:0]              i_read_data,
  output logic                    o_busy
);

  logic scl_rise;
  logic scl_fall;
  logic sda_s;
  logic start_evt;
  logic stop_evt;

  iic_line_sync u_line_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl      (i_iic_scl),
    .i_sda      (i_iic_sda),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_sda_s    (sda_s),
    .o_start    (start_evt),
    .o_stop     (stop_evt)
  );

  iic_state_e              state_q, state_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              shift_q, shift_d;
  logic [P_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [1:0]              op_q, op_d;
  logic                    oe_q, oe_d;
  logic                    busy_q, busy_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [P_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic                    rd_req_q, rd_req_d;
  logic [P_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                    rd_load_q;
  logic [7:0]              rx_byte;

  assign rx_byte = {shift_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;

    // Read data arrives one cycle after the request; it lands well before the
    // next SCL fall because SCL is at least 16x slower than the clock.
    if (rd_load_q) begin
      shift_d = i_read_data;
      ptr_d   = ptr_q + P_ADDR_WIDTH'(1);
    end

    if (stop_evt) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_evt) begin
      state_d   = ST_DEV;
      bit_cnt_d = 4'd0;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        ST_DEV, ST_ADDR_H, ST_ADDR_L, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == BIT_LAST_RX) begin
              case (state_q)
                ST_DEV: begin
                  if (rx_byte[7:1] == P_DEVICE_ADDR) begin
                    state_d = ST_ACK_DEV;
                    busy_d  = 1'b1;
                    op_d    = rx_byte[0] ? P_R : P_W;
                  end else begin
                    state_d = ST_IGNORE;
                    busy_d  = 1'b0;
                  end
                end
                ST_ADDR_H: begin
                  ptr_d   = P_ADDR_WIDTH'({rx_byte, ptr_q[7:0]});
                  state_d = ST_ACK_AH;
                end
                ST_ADDR_L: begin
                  ptr_d   = (ptr_q & ~P_ADDR_WIDTH'(8'hFF)) | P_ADDR_WIDTH'(rx_byte);
                  state_d = ST_ACK_AL;
                end
                default: begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = rx_byte;
                  state_d    = ST_ACK_WD;
                end
              endcase
            end
          end
        end

        // ACK states: pull SDA at the fall ending bit 8, release at the fall
        // ending the 9th clock.
        ST_ACK_DEV, ST_ACK_AH, ST_ACK_AL, ST_ACK_WD: begin
          if (scl_fall) begin
            if (bit_cnt_q == BIT_BYTE_END) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = 4'd0;
              case (state_q)
                ST_ACK_DEV: begin
                  if (op_q == P_R) begin
                    state_d = ST_RDATA;
                    oe_d    = ~shift_q[7];
                  end else begin
                    state_d = (P_ADDR_WIDTH == 8) ? ST_ADDR_L : ST_ADDR_H;
                  end
                end
                ST_ACK_AH: state_d = ST_ADDR_L;
                ST_ACK_AL: state_d = ST_WDATA;
                default: begin
                  state_d = ST_WDATA;
                  ptr_d   = ptr_q + P_ADDR_WIDTH'(1);
                end
              endcase
            end
          end else if (scl_rise) begin
            bit_cnt_d = BIT_ACK_HIGH;
            if (state_q == ST_ACK_DEV && op_q == P_R) begin
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q;
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == BIT_BYTE_END) begin
              oe_d    = 1'b0;
              state_d = ST_MACK;
            end else begin
              oe_d = ~shift_q[3'd7 - bit_cnt_q[2:0]];
            end
          end
        end

        ST_MACK: begin
          if (scl_rise) begin
            bit_cnt_d = BIT_ACK_HIGH;
            if (!sda_s) begin
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q;
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && bit_cnt_q == BIT_ACK_HIGH) begin
            state_d   = ST_RDATA;
            bit_cnt_d = 4'd0;
            oe_d      = ~shift_q[7];
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      op_q       <= P_W;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      rd_load_q  <= rd_req_q;
    end
  end

  assign o_iic_sda_oe  = oe_q;
  assign o_busy        = busy_q;
  assign o_write_valid = wr_valid_q;
  assign o_write_addr  = wr_addr_q;
  assign o_write_data  = wr_data_q;
  assign o_read_req    = rd_req_q;
  assign o_read_addr   = rd_addr_q;

endmodule

// File: tb/tb_iic_slave_drive.sv
// Bench: bit-banged I2C master against a 16-bit-address responder (0x50) and
// an 8-bit-address responder (0x52) sharing one open-drain bus.
module tb_iic_slave_drive;

  localparam int Q = 10;  // quarter SCL period in clocks (SCL = clk/40)

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic oe16, oe8;
  wire  sda_line = sda_m & ~oe16 & ~oe8;

  logic [15:0] wa16, ra16;
  logic [7:0]  wd16, rdata16;
  logic        wv16, rq16, busy16;
  logic [7:0]  wa8, ra8, wd8;
  logic [7:0]  rdata8 = 8'h00;
  logic        wv8, rq8, busy8;

  iic_slave_drive dut16 (
    .i_clk(clk), .i_rst(rst), .i_iic_scl(scl_m), .i_iic_sda(sda_line),
    .o_iic_sda_oe(oe16), .o_write_addr(wa16), .o_write_data(wd16),
    .o_write_valid(wv16), .o_read_addr(ra16), .o_read_req(rq16),
    .i_read_data(rdata16), .o_busy(busy16)
  );

  iic_slave_drive #(.P_DEVICE_ADDR(7'h52), .P_ADDR_WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_iic_scl(scl_m), .i_iic_sda(sda_line),
    .o_iic_sda_oe(oe8), .o_write_addr(wa8), .o_write_data(wd8),
    .o_write_valid(wv8), .o_read_addr(ra8), .o_read_req(rq8),
    .i_read_data(rdata8), .o_busy(busy8)
  );

  // Local memory behind dut16: untouched locations hold a seeded pattern.
  logic [7:0] seed;
  bit   [7:0] mem     [0:65535];
  bit         written [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [15:0] ref_ptr;
  logic [31:0] wq16[$], wq8[$], rdq[$];
  logic [7:0]  wdata[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ seed;
  endfunction

  always @(posedge clk) begin
    if (wv16) begin
      mem[wa16]     <= wd16;
      written[wa16] <= 1'b1;
      wq16.push_back({8'h00, wa16, wd16});
    end
    if (rq16) begin
      rdata16 <= written[ra16] ? mem[ra16] : init_byte(ra16);
      rdq.push_back({16'h0000, ra16});
    end
    if (wv8) wq8.push_back({16'h0000, wa8, wd8});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start();
    sda_m = 1'b1; tick(); scl_m = 1'b1; tick(); sda_m = 1'b0; tick(); scl_m = 1'b0; tick();
  endtask

  task automatic m_stop();
    sda_m = 1'b0; tick(); scl_m = 1'b1; tick(); sda_m = 1'b1; tick();
  endtask

  task automatic m_bit(input logic b, output logic s);
    sda_m = b; tick(); scl_m = 1'b1; tick(); s = sda_line; tick(); scl_m = 1'b0; tick();
  endtask

  task automatic m_wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic m_rbyte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, s);
      b[i] = s;
    end
    m_bit(~ack, s);
  endtask

  // Write wdata[] starting at addr; model: byte i lands at (addr+i) mod 2^16.
  task automatic write_txn(input logic [15:0] addr, input string tag);
    logic ack;
    int acks = 0;
    int n = wdata.size();
    wq16.delete();
    m_start();
    m_wbyte(8'hA0, ack);       acks += int'(ack);
    m_wbyte(addr[15:8], ack);  acks += int'(ack);
    m_wbyte(addr[7:0], ack);   acks += int'(ack);
    for (int i = 0; i < n; i++) begin
      m_wbyte(wdata[i], ack);
      acks += int'(ack);
      ref_mem[16'(addr + 16'(i))] = wdata[i];
    end
    m_stop(); tick();
    check({tag, "_acks"}, 32'(acks), 32'(n + 3));
    check({tag, "_nstrobe"}, 32'(wq16.size()), 32'(n));
    for (int i = 0; i < n && i < wq16.size(); i++)
      check({tag, "_strobe"}, wq16[i], {8'h00, 16'(addr + 16'(i)), wdata[i]});
    ref_ptr = 16'(addr + 16'(n));
  endtask

  // Read n bytes (ACK all but the last); set_addr selects random vs current-address read.
  task automatic read_txn(input logic set_addr, input logic [15:0] addr, input int n, input string tag);
    logic ack;
    logic [7:0] b;
    int acks = 0;
    logic [15:0] base;
    base = set_addr ? addr : ref_ptr;
    rdq.delete();
    m_start();
    if (set_addr) begin
      m_wbyte(8'hA0, ack);       acks += int'(ack);
      m_wbyte(addr[15:8], ack);  acks += int'(ack);
      m_wbyte(addr[7:0], ack);   acks += int'(ack);
      m_start();
    end
    m_wbyte(8'hA1, ack); acks += int'(ack);
    check({tag, "_busy_hi"}, 32'(busy16), 32'd1);
    for (int i = 0; i < n; i++) begin
      m_rbyte(i != n - 1, b);
      check({tag, "_rdbyte"}, 32'(b), 32'(ref_mem[16'(base + 16'(i))]));
    end
    check({tag, "_busy_nack"}, 32'(busy16), 32'd0);
    m_stop(); tick();
    check({tag, "_acks"}, 32'(acks), set_addr ? 32'd4 : 32'd1);
    check({tag, "_nreq"}, 32'(rdq.size()), 32'(n));
    for (int i = 0; i < n && i < rdq.size(); i++)
      check({tag, "_reqaddr"}, rdq[i], 32'(16'(base + 16'(i))));
    ref_ptr = 16'(base + 16'(n));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ack, s;
    int acks;
    logic [15:0] ra;
    int n, waited;

    seed = 8'($urandom);
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
    ref_ptr = 16'h0000;

    repeat (5) @(posedge clk);
    #1;
    check("rst_oe", 32'(oe16), 32'd0);
    check("rst_wv", 32'(wv16), 32'd0);
    check("rst_rq", 32'(rq16), 32'd0);
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_wa", 32'(wa16), 32'd0);
    check("rst_ra", 32'(ra16), 32'd0);
    check("rst_wd", 32'(wd16), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // three-byte write
    wdata.delete();
    wdata.push_back(8'h11); wdata.push_back(8'h22); wdata.push_back(8'h33);
    write_txn(16'h0123, "wr3");

    // random read across a byte boundary, then current-address read
    read_txn(1'b1, 16'h00FE, 3, "rdFE");
    read_txn(1'b0, 16'h0000, 1, "rdcur");

    // wrong device address: no ACK, no activity until STOP
    wq16.delete(); rdq.delete();
    m_start();
    m_wbyte(8'hA2, ack);
    check("wrong_dev_ack", 32'(ack), 32'd0);
    m_wbyte(8'h12, ack);
    check("wrong_data_ack", 32'(ack), 32'd0);
    check("wrong_busy", 32'(busy16), 32'd0);
    m_stop(); tick();
    check("wrong_nstrobe", 32'(wq16.size()), 32'd0);
    check("wrong_nreq", 32'(rdq.size()), 32'd0);

    // pointer wrap
    wdata.delete();
    wdata.push_back(8'($urandom)); wdata.push_back(8'($urandom));
    write_txn(16'hFFFF, "wrap");

    // abort a data byte after 4 bits
    wq16.delete();
    acks = 0;
    m_start();
    m_wbyte(8'hA0, ack); acks += int'(ack);
    m_wbyte(8'h40, ack); acks += int'(ack);
    m_wbyte(8'h00, ack); acks += int'(ack);
    for (int i = 0; i < 4; i++) m_bit(1'($urandom), s);
    m_stop(); tick();
    check("abort_acks", 32'(acks), 32'd3);
    check("abort_nstrobe", 32'(wq16.size()), 32'd0);
    check("abort_busy", 32'(busy16), 32'd0);
    check("abort_oe", 32'(oe16), 32'd0);
    ref_ptr = 16'h4000;
    read_txn(1'b0, 16'h0000, 1, "abort_rd");

    // 8-bit address build (device 0x52)
    wq8.delete(); wq16.delete();
    acks = 0;
    m_start();
    m_wbyte(8'hA4, ack); acks += int'(ack);
    m_wbyte(8'h7F, ack); acks += int'(ack);
    m_wbyte(8'h55, ack); acks += int'(ack);
    m_stop(); tick();
    check("a8_acks", 32'(acks), 32'd3);
    check("a8_nstrobe", 32'(wq8.size()), 32'd1);
    if (wq8.size() > 0) check("a8_strobe", wq8[0], 32'h00007F55);
    check("a8_other_nstrobe", 32'(wq16.size()), 32'd0);

    // randomized write then read-back
    for (int k = 0; k < 4; k++) begin
      ra = 16'($urandom);
      n = $urandom_range(1, 3);
      wdata.delete();
      for (int j = 0; j < n; j++) wdata.push_back(8'($urandom));
      write_txn(ra, "rndwr");
      read_txn(1'b1, ra, n, "rndrd");
    end

    // reset in the middle of a read while SDA is being pulled low
    wdata.delete();
    wdata.push_back(8'h00);
    write_txn(16'h2000, "rstprep");
    m_start();
    m_wbyte(8'hA0, ack); m_wbyte(8'h20, ack); m_wbyte(8'h00, ack);
    m_start();
    m_wbyte(8'hA1, ack);
    waited = 0;
    while (!oe16 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("rst_mid_drive", 32'(oe16), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_oe", 32'(oe16), 32'd0);
    check("rst_mid_busy", 32'(busy16), 32'd0);
    check("rst_mid_wv", 32'(wv16), 32'd0);
    check("rst_mid_rq", 32'(rq16), 32'd0);
    check("rst_mid_wa", 32'(wa16), 32'd0);
    check("rst_mid_ra", 32'(ra16), 32'd0);
    check("rst_mid_wd", 32'(wd16), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    m_stop(); tick();
    ref_ptr = 16'h0000;
    read_txn(1'b0, 16'h0000, 1, "post_rst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
